// File: rtl/instr_decode_stage.sv
// RV32 instruction decoder feeding a DEPTH-entry result FIFO; an accepted word is visible at the head one cycle later.
// in_ready drops only when the FIFO is full, on flush, or before the first clock after reset; it never looks at out_ready.
module instr_decode_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [6:0]               opcode,
  output logic [4:0]               rd,
  output logic [4:0]               rs1,
  output logic [4:0]               rs2,
  output logic [2:0]               funct3,
  output logic [6:0]               funct7,
  output logic [XLEN-1:0]          imm,
  output logic [2:0]               fmt,
  output logic                     illegal,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F_R   = 3'd0;
  localparam logic [2:0] F_I   = 3'd1;
  localparam logic [2:0] F_S   = 3'd2;
  localparam logic [2:0] F_B   = 3'd3;
  localparam logic [2:0] F_U   = 3'd4;
  localparam logic [2:0] F_J   = 3'd5;
  localparam logic [2:0] F_ILL = 3'd7;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } dec_t;

  dec_t               dec;
  dec_t               head;
  dec_t               mem [DEPTH];
  logic signed [31:0] imm32;
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic               rdy_en;
  logic               push;
  logic               pop;

  always_comb begin
    dec   = '0;
    imm32 = '0;
    dec.opcode = instr[6:0];
    case (instr[6:0])
      OP_LOAD, OP_IMM, OP_JALR: begin
        dec.fmt    = F_I;
        dec.rd     = instr[11:7];
        dec.rs1    = instr[19:15];
        dec.funct3 = instr[14:12];
        imm32      = {{20{instr[31]}}, instr[31:20]};
      end
      OP_STORE: begin
        dec.fmt    = F_S;
        dec.rs1    = instr[19:15];
        dec.rs2    = instr[24:20];
        dec.funct3 = instr[14:12];
        imm32      = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OP_REG: begin
        dec.fmt    = F_R;
        dec.rd     = instr[11:7];
        dec.rs1    = instr[19:15];
        dec.rs2    = instr[24:20];
        dec.funct3 = instr[14:12];
        dec.funct7 = instr[31:25];
      end
      OP_BRANCH: begin
        dec.fmt    = F_B;
        dec.rs1    = instr[19:15];
        dec.rs2    = instr[24:20];
        dec.funct3 = instr[14:12];
        imm32      = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        dec.fmt = F_U;
        dec.rd  = instr[11:7];
        imm32   = {instr[31:12], 12'b0};
      end
      OP_JAL: begin
        dec.fmt = F_J;
        dec.rd  = instr[11:7];
        imm32   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      default: begin
        // Unsupported opcodes still occupy a slot so ordering is kept downstream.
        dec.opcode  = '0;
        dec.fmt     = F_ILL;
        dec.illegal = 1'b1;
      end
    endcase
    dec.imm = XLEN'(imm32);
  end

  assign out_valid = (count != '0);
  assign in_ready  = rdy_en & (count < FULL) & ~flush;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dec;
  end

  // Gating on out_valid keeps every field at zero while empty or in reset.
  assign head    = out_valid ? mem[rd_ptr] : '0;
  assign opcode  = head.opcode;
  assign rd      = head.rd;
  assign rs1     = head.rs1;
  assign rs2     = head.rs2;
  assign funct3  = head.funct3;
  assign funct7  = head.funct7;
  assign imm     = head.imm;
  assign fmt     = head.fmt;
  assign illegal = head.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Scoreboarded bench: a 32-bit and a 64-bit decoder share one input stream and one expected-result queue.
module tb_instr_decode_stage;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid;
  logic        out_ready = 1'b0;
  logic [31:0] instr;

  logic        a_in_ready, a_out_valid, a_illegal;
  logic [6:0]  a_opcode, a_funct7;
  logic [4:0]  a_rd, a_rs1, a_rs2;
  logic [2:0]  a_funct3, a_fmt;
  logic [31:0] a_imm;
  logic [1:0]  a_count;

  logic        b_in_ready, b_out_valid, b_illegal;
  logic [6:0]  b_opcode, b_funct7;
  logic [4:0]  b_rd, b_rs1, b_rs2;
  logic [2:0]  b_funct3, b_fmt;
  logic [63:0] b_imm;
  logic [1:0]  b_count;

  always #5 clk = ~clk;

  instr_decode_stage #(.XLEN(32), .DEPTH(DEPTH)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .instr(instr), .out_valid(a_out_valid), .out_ready(out_ready), .opcode(a_opcode),
    .rd(a_rd), .rs1(a_rs1), .rs2(a_rs2), .funct3(a_funct3), .funct7(a_funct7),
    .imm(a_imm), .fmt(a_fmt), .illegal(a_illegal), .count(a_count));

  instr_decode_stage #(.XLEN(64), .DEPTH(DEPTH)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .instr(instr), .out_valid(b_out_valid), .out_ready(out_ready), .opcode(b_opcode),
    .rd(b_rd), .rs1(b_rs1), .rs2(b_rs2), .funct3(b_funct3), .funct7(b_funct7),
    .imm(b_imm), .fmt(b_fmt), .illegal(b_illegal), .count(b_count));

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        illegal;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  bit   live = 1'b0;
  bit   rand_sink = 1'b0;
  bit   fixed_rdy = 1'b0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  // Reference decode: format from the opcode table, fields kept by format, immediates by signed arithmetic.
  function automatic exp_t model(input logic [31:0] w);
    exp_t   e;
    longint s;
    e = '0;
    s = longint'($signed(w));
    case (w[6:0])
      7'h03, 7'h13, 7'h67: e.fmt = 3'd1;
      7'h23:               e.fmt = 3'd2;
      7'h33:               e.fmt = 3'd0;
      7'h63:               e.fmt = 3'd3;
      7'h37, 7'h17:        e.fmt = 3'd4;
      7'h6F:               e.fmt = 3'd5;
      default:             e.fmt = 3'd7;
    endcase
    if (e.fmt == 3'd7) begin
      e.illegal = 1'b1;
      return e;
    end
    e.opcode = w[6:0];
    e.rd     = (e.fmt == 3'd2 || e.fmt == 3'd3) ? 5'd0 : w[11:7];
    e.rs1    = (e.fmt >= 3'd4) ? 5'd0 : w[19:15];
    e.rs2    = (e.fmt == 3'd0 || e.fmt == 3'd2 || e.fmt == 3'd3) ? w[24:20] : 5'd0;
    e.funct3 = (e.fmt >= 3'd4) ? 3'd0 : w[14:12];
    e.funct7 = (e.fmt == 3'd0) ? w[31:25] : 7'd0;
    case (e.fmt)
      3'd1: e.imm = s >>> 20;
      3'd2: e.imm = ((s >>> 25) << 5) | longint'(w[11:7]);
      3'd3: e.imm = ((s >>> 31) << 12) | (longint'(w[7]) << 11) | (longint'(w[30:25]) << 5)
                    | (longint'(w[11:8]) << 1);
      3'd4: e.imm = (s >>> 12) << 12;
      3'd5: e.imm = ((s >>> 31) << 20) | (longint'(w[19:12]) << 12) | (longint'(w[20]) << 11)
                    | (longint'(w[30:21]) << 1);
      default: e.imm = 64'd0;
    endcase
    return e;
  endfunction

  function automatic exp_t got_a();
    exp_t g;
    g = '{a_opcode, a_rd, a_rs1, a_rs2, a_funct3, a_funct7, {32'd0, a_imm}, a_fmt, a_illegal};
    return g;
  endfunction

  function automatic exp_t got_b();
    exp_t g;
    g = '{b_opcode, b_rd, b_rs1, b_rs2, b_funct3, b_funct7, b_imm, b_fmt, b_illegal};
    return g;
  endfunction

  always @(posedge clk) begin
    #2;
    out_ready = rand_sink ? ($urandom_range(0, 3) != 0) : fixed_rdy;
  end

  // Monitor: head must match the oldest expectation; the DUT pops it at the next edge.
  always @(negedge clk) begin
    exp_t e32;
    check("count_a", 128'(a_count), 128'(q.size()));
    check("count_b", 128'(b_count), 128'(q.size()));
    check("out_valid_a", 128'(a_out_valid), 128'(q.size() != 0));
    check("out_valid_b", 128'(b_out_valid), 128'(q.size() != 0));
    if (live) begin
      check("in_ready_a", 128'(a_in_ready), 128'(q.size() < DEPTH && !flush));
      check("in_ready_b", 128'(b_in_ready), 128'(q.size() < DEPTH && !flush));
    end
    if (q.size() != 0) begin
      e32 = q[0];
      e32.imm = {32'd0, q[0].imm[31:0]};
      check("head_a", 128'(got_a()), 128'(e32));
      check("head_b", 128'(got_b()), 128'(q[0]));
      if (a_out_valid && out_ready && !flush) void'(q.pop_front());
    end
  end

  task automatic send(input logic [31:0] w);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    instr = w;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = a_in_ready;
      @(posedge clk);
      if (acc) q.push_back(model(w));
      #1;
    end
    in_valid = 1'b0;
    if (!acc) check("send_timeout", 128'd0, 128'd1);
  endtask

  task automatic drain();
    fixed_rdy = 1'b1;
    for (int i = 0; i < 100 && q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    if (q.size() != 0) check("drain_timeout", 128'(q.size()), 128'd0);
    fixed_rdy = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_out_valid"}, 128'({a_out_valid, b_out_valid}), 128'd0);
    check({tag, "_in_ready"}, 128'({a_in_ready, b_in_ready}), 128'd0);
    check({tag, "_count"}, 128'({a_count, b_count}), 128'd0);
    check({tag, "_fields"}, 128'(got_b()), 128'd0);
  endtask

  initial begin
    static logic [6:0] ops [9] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h33, 7'h63, 7'h37, 7'h17, 7'h6F};
    logic [31:0] w;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; instr = '0;
    #12;
    reset_checks("reset");
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", 128'(a_in_ready), 128'd0);
    @(posedge clk);
    #1;
    check("ready_after_edge", 128'({a_in_ready, b_in_ready}), 128'b11);
    live = 1'b1;

    send(32'hFFF00093);
    check("addi_valid", 128'(a_out_valid), 128'd1);
    check("addi_fmt_rd", 128'({a_fmt, a_rd, a_rs1, a_funct3}), 128'({3'd1, 5'd1, 5'd0, 3'd0}));
    check("addi_imm32", 128'(a_imm), 128'h0000_0000_FFFF_FFFF);
    check("addi_imm64", 128'(b_imm), 128'hFFFF_FFFF_FFFF_FFFF);
    drain();

    send(32'hFE208EE3);
    check("beq_fields", 128'({a_fmt, a_rs1, a_rs2, a_rd}), 128'({3'd3, 5'd1, 5'd2, 5'd0}));
    check("beq_imm", 128'(a_imm), 128'h0000_0000_FFFF_FFFC);
    drain();
    send(32'h0020A423);
    check("sw_fmt", 128'(a_fmt), 128'd2);
    check("sw_imm", 128'(a_imm), 128'h8);
    drain();

    send(32'h123452B7);
    check("lui_fields", 128'({a_fmt, a_rd}), 128'({3'd4, 5'd5}));
    check("lui_imm32", 128'(a_imm), 128'h1234_5000);
    check("lui_imm64", 128'(b_imm), 128'h0000_0000_1234_5000);
    drain();

    send(32'h0000_0000);
    check("illegal_head", 128'(got_b()), 128'({7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd0, 3'd7, 1'b1}));
    send(32'hFFF00093);
    drain();

    // Full FIFO holds the third word until a slot frees.
    send(32'h00500093);
    send(32'h00A00113);
    fork
      send(32'h00F00193);
    join_none
    repeat (2) begin
      check("full_ready", 128'(a_in_ready), 128'd0);
      check("full_count", 128'(a_count), 128'd2);
      @(posedge clk);
      #1;
    end
    fixed_rdy = 1'b1;
    @(negedge clk); check("drain_seq0", 128'(a_count), 128'd2);
    @(negedge clk); check("drain_seq1", 128'(a_count), 128'd1);
    @(negedge clk); check("drain_seq2", 128'(a_count), 128'd1);
    @(negedge clk); check("drain_seq3", 128'(a_count), 128'd0);
    wait fork;
    fixed_rdy = 1'b0;
    @(posedge clk);
    #1;

    send(32'h00100093);
    send(32'h00200113);
    flush = 1'b1; in_valid = 1'b1; instr = 32'h00300193;
    @(negedge clk);
    check("flush_ready", 128'(a_in_ready), 128'd0);
    @(posedge clk);
    q.delete();
    #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_empty", 128'({a_count, a_out_valid, b_count, b_out_valid}), 128'd0);
    fixed_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    fixed_rdy = 1'b0;

    send(32'h00100093);
    send(32'h00200113);
    #2;
    rst_n = 1'b0;
    live = 1'b0;
    #1;
    reset_checks("midreset");
    q.delete();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("rerelease_ready", 128'(a_in_ready), 128'd0);
    @(posedge clk);
    #1;
    check("rerelease_ready_edge", 128'(a_in_ready), 128'd1);
    live = 1'b1;

    rand_sink = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        flush = 1'b1;
        @(posedge clk);
        q.delete();
        #1;
        flush = 1'b0;
      end else if ($urandom_range(0, 5) == 0) begin
        @(posedge clk);
        #1;
      end else begin
        w = $urandom();
        if ($urandom_range(0, 4) != 0) w[6:0] = ops[$urandom_range(0, 8)];
        send(w);
      end
    end
    rand_sink = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
